rc4_key_search_core: RTL and testbench
======================================

# rc4_key_search_core

Parametrised RC4 key-search engine: iterates candidate keys over a programmable range and, for each, runs S-init, the key schedule and the PRGA/decrypt over a loaded ciphertext. It rejects a key at the first plaintext byte outside the accepted character set. It stops on the first accepted key or when the range is exhausted. It replaces the fixed single-key, fixed-length KSA/shuffle/decrypt chain, with key width, key length, message depth and check mode as parameters; several instances can split a key space in parallel.

## Interface
- KEY_BYTES, 3: secret-key length in bytes; key byte index is `i mod KEY_BYTES`.
- KEY_BITS, 22: searched key width, ≤ KEY_BYTES*8; key zero-extended on the left, byte 0 = most significant.
- MSG_DEP, 32: ciphertext/plaintext length in bytes.
- CHECK_EN, 1: 1 = search with early reject; 0 = decrypt key_lo only, no checking, always report found.
- CLOCK_50  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- abort  in  1  level; forces return to IDLE.
- key_lo, key_hi  in  KEY_BITS  inclusive search range, sampled at start.
- ct_wr_en  in  1  ciphertext write strobe; honoured only when not busy.
- ct_wr_addr  in  $clog2(MSG_DEP)  ciphertext byte address.
- ct_wr_data  in  8  ciphertext byte.
- pt_rd_addr  in  $clog2(MSG_DEP)  plaintext read address.
- pt_rd_data  out  8  plaintext byte, combinational from buffer.
- busy  out  1  high from the cycle after start until completion.
- done  out  1  level; search finished. Held until the next accepted start.
- found  out  1  level, valid with done; 1 = key accepted.
- found_key  out  KEY_BITS  accepted key, valid when found.
- cur_key  out  KEY_BITS  key under test, for status/LEDs.

## Operation
- Reset values: busy=0, done=0, found=0, found_key=0, cur_key=0, state IDLE, i=j=0. S, ct and pt arrays are not reset.
- States: IDLE, INIT, KSA_J, KSA_SWAP, PRGA_IJ, PRGA_SWAP, PRGA_OUT, NEXT_KEY, FINISH.
- IDLE: when start=1, latch range, cur_key<=key_lo, clear done/found.
  - If key_lo>key_hi (CHECK_EN=1), go to FINISH with found=0.
  - Otherwise go to INIT.
- INIT (1 cycle): S[n]<=n for all n in parallel; i<=0, j<=0.
- KSA_J: j<=j+S[i]+keybyte[i mod KEY_BYTES], mod 256.
- KSA_SWAP: swap S[i], S[j]. If i==255, clear i, j and k and go to PRGA_IJ; else i++ and go to KSA_J.
- PRGA_IJ: i<=i+1; j<=j+S[i+1].
- PRGA_SWAP: swap S[i], S[j].
- PRGA_OUT: pt[k]<=S[(S[i]+S[j]) mod 256] ^ ct[k].
  - CHECK_EN=1 and byte not in {0x61..0x7A, 0x20}: go to NEXT_KEY.
  - k==MSG_DEP-1: found<=1, found_key<=cur_key, go to FINISH.
  - Otherwise k++ and go to PRGA_IJ.
- NEXT_KEY: if cur_key==key_hi, found<=0 and go to FINISH; else cur_key++ and go to INIT. The compare happens before the increment, so key_hi = all-ones does not wrap.
- FINISH: done<=1, busy<=0, then IDLE.
- All index arithmetic is 8-bit wrap-around; k wraps at MSG_DEP-1 only via the exit above.
- abort=1 in any non-IDLE state: the next state is IDLE with busy=0, done=0, found=0. abort in IDLE has no effect.
- start while busy is ignored. ct_wr_en while busy is ignored.
- reset mid-search: behaves as abort, and also clears all outputs to their reset values.

## Timing
- Start sampled at edge N: busy=1 from N+1.
- Per key: INIT 1 cycle, KSA 512 cycles, PRGA 3 cycles per byte processed (the rejected byte included), NEXT_KEY 1 cycle.
- Fully accepted key: 1+512+3*MSG_DEP cycles, then FINISH; done=1 on the following cycle.
- Rejected key after m bytes: 514+3m cycles before the next INIT.
- pt_rd_data: zero-latency read; contents are stable only when busy=0.

## Structure
- Package rc4_pkg: state enum, S_DEP=256 constant, `is_accepted_char` function, key-byte select function.
- Sub-module rc4_msg_buffer: dual MSG_DEP×8 register buffer for ct (external write port) and pt (engine write port, external combinational read).
- The S array (256×8 registers), FSM and key counter live in the top module.

## Test plan
- CHECK_EN=0, KEY_BYTES=3, KEY_BITS=24, MSG_DEP=9, key_lo=0x4B6579 ("Key"), ct=BB F3 16 E8 D9 40 AF 0A D3 → found=1 and pt reads "Plaintext". done rises 1+512+27+1 cycles after busy rises.
- CHECK_EN=1, MSG_DEP=32, ct from the model for key 0x000049 and a lowercase/space message, range 0x40..0x50 → found=1, found_key=0x000049, pt matches the message.
- Same ct, range 0x50..0x60 → done=1, found=0, cur_key=0x60.
- key_lo=0x10, key_hi=0x0F → busy for 1 cycle, then done=1, found=0, no S activity.
- Mid-KSA: assert abort (a second run asserts reset instead), then issue a new start → busy=0 and done=0 the next cycle; the new search produces the same result as a clean run.
- start pulse and ct_wr_en while busy → both ignored: result and ct unchanged, search unaffected.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared types and helpers for the RC4 key-search engine.
package rc4_pkg;

  localparam int unsigned S_DEP        = 256;
  localparam int unsigned KEY_MAX_BITS = 256;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_KSA_J,
    ST_KSA_SWAP,
    ST_PRGA_IJ,
    ST_PRGA_SWAP,
    ST_PRGA_OUT,
    ST_NEXT_KEY,
    ST_FINISH
  } rc4_state_e;

  // Lowercase letters and space are the only plaintext bytes a candidate key may produce.
  function automatic logic is_accepted_char(input logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
  endfunction

  // Byte idx of an nbytes-long key, byte 0 being the most significant.
  function automatic logic [7:0] key_byte(input logic [KEY_MAX_BITS-1:0] key_ext,
                                          input int unsigned nbytes,
                                          input int unsigned idx);
    logic [KEY_MAX_BITS-1:0] sh;
    sh = key_ext >> (8 * (nbytes - 1 - idx));
    return sh[7:0];
  endfunction

endpackage

// File: rtl/rc4_msg_buffer.sv
// Ciphertext and plaintext register buffers; ct written externally, pt written by the engine.
module rc4_msg_buffer #(
  parameter int unsigned MSG_DEP = 32,
  parameter int unsigned AW      = $clog2(MSG_DEP)
) (
  input  logic          clk_i,
  input  logic          ct_we_i,
  input  logic [AW-1:0] ct_waddr_i,
  input  logic [7:0]    ct_wdata_i,
  input  logic [AW-1:0] ct_raddr_i,
  output logic [7:0]    ct_rdata_o,
  input  logic          pt_we_i,
  input  logic [AW-1:0] pt_waddr_i,
  input  logic [7:0]    pt_wdata_i,
  input  logic [AW-1:0] pt_raddr_i,
  output logic [7:0]    pt_rdata_o
);

  logic [7:0] ct_q [MSG_DEP];
  logic [7:0] pt_q [MSG_DEP];

  always_ff @(posedge clk_i) begin
    if (ct_we_i && (32'(ct_waddr_i) < MSG_DEP)) ct_q[ct_waddr_i] <= ct_wdata_i;
    if (pt_we_i && (32'(pt_waddr_i) < MSG_DEP)) pt_q[pt_waddr_i] <= pt_wdata_i;
  end

  assign ct_rdata_o = (32'(ct_raddr_i) < MSG_DEP) ? ct_q[ct_raddr_i] : '0;
  assign pt_rdata_o = (32'(pt_raddr_i) < MSG_DEP) ? pt_q[pt_raddr_i] : '0;

endmodule

// File: rtl/rc4_key_search_core.sv
// RC4 key-search engine: per candidate key runs S-init, KSA and PRGA/decrypt,
// rejecting a key at the first plaintext byte outside the accepted set.
module rc4_key_search_core
  import rc4_pkg::*;
#(
  parameter int unsigned KEY_BYTES = 3,
  parameter int unsigned KEY_BITS  = 22,
  parameter int unsigned MSG_DEP   = 32,
  parameter bit          CHECK_EN  = 1'b1
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [KEY_BITS-1:0]        key_lo,
  input  logic [KEY_BITS-1:0]        key_hi,
  input  logic                       ct_wr_en,
  input  logic [$clog2(MSG_DEP)-1:0] ct_wr_addr,
  input  logic [7:0]                 ct_wr_data,
  input  logic [$clog2(MSG_DEP)-1:0] pt_rd_addr,
  output logic [7:0]                 pt_rd_data,
  output logic                       busy,
  output logic                       done,
  output logic                       found,
  output logic [KEY_BITS-1:0]        found_key,
  output logic [KEY_BITS-1:0]        cur_key
);

  localparam int unsigned AW  = $clog2(MSG_DEP);
  localparam int unsigned KIW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  rc4_state_e          state_q, state_d;
  logic [7:0]          i_q, i_d, j_q, j_d;
  logic [AW-1:0]       k_q, k_d;
  logic [KIW-1:0]      kidx_q, kidx_d;
  logic [KEY_BITS-1:0] cur_key_q, cur_key_d, key_hi_q, key_hi_d;
  logic [KEY_BITS-1:0] found_key_q, found_key_d;
  logic                busy_q, busy_d, done_q, done_d, found_q, found_d;

  logic [7:0] s_q [S_DEP];

  logic [KEY_MAX_BITS-1:0] key_ext;
  logic [7:0]              key_bytes [KEY_BYTES];
  logic [7:0]              si, sj, si1, i_inc, ks_idx, ks, ct_k, pt_byte;
  logic                    pt_we, ct_we;

  always_comb begin
    key_ext = KEY_MAX_BITS'(cur_key_q);
    for (int unsigned b = 0; b < KEY_BYTES; b++) key_bytes[b] = key_byte(key_ext, KEY_BYTES, b);
  end

  assign i_inc   = i_q + 8'd1;
  assign si      = s_q[i_q];
  assign sj      = s_q[j_q];
  assign si1     = s_q[i_inc];
  assign ks_idx  = si + sj;
  assign ks      = s_q[ks_idx];
  assign pt_byte = ks ^ ct_k;
  assign ct_we   = ct_wr_en && !busy_q;

  rc4_msg_buffer #(
    .MSG_DEP (MSG_DEP),
    .AW      (AW)
  ) u_buf (
    .clk_i      (CLOCK_50),
    .ct_we_i    (ct_we),
    .ct_waddr_i (ct_wr_addr),
    .ct_wdata_i (ct_wr_data),
    .ct_raddr_i (k_q),
    .ct_rdata_o (ct_k),
    .pt_we_i    (pt_we),
    .pt_waddr_i (k_q),
    .pt_wdata_i (pt_byte),
    .pt_raddr_i (pt_rd_addr),
    .pt_rdata_o (pt_rd_data)
  );

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    kidx_d      = kidx_q;
    cur_key_d   = cur_key_q;
    key_hi_d    = key_hi_q;
    found_key_d = found_key_q;
    busy_d      = busy_q;
    done_d      = done_q;
    found_d     = found_q;
    pt_we       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cur_key_d = key_lo;
          key_hi_d  = key_hi;
          done_d    = 1'b0;
          found_d   = 1'b0;
          busy_d    = 1'b1;
          state_d   = (CHECK_EN && (key_lo > key_hi)) ? ST_FINISH : ST_INIT;
        end
      end
      ST_INIT: begin
        i_d     = '0;
        j_d     = '0;
        kidx_d  = '0;
        state_d = ST_KSA_J;
      end
      ST_KSA_J: begin
        j_d     = j_q + si + key_bytes[kidx_q];
        state_d = ST_KSA_SWAP;
      end
      ST_KSA_SWAP: begin
        if (i_q == 8'hFF) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = ST_PRGA_IJ;
        end else begin
          i_d     = i_inc;
          kidx_d  = (32'(kidx_q) == KEY_BYTES - 1) ? '0 : kidx_q + KIW'(1);
          state_d = ST_KSA_J;
        end
      end
      ST_PRGA_IJ: begin
        i_d     = i_inc;
        j_d     = j_q + si1;
        state_d = ST_PRGA_SWAP;
      end
      ST_PRGA_SWAP: state_d = ST_PRGA_OUT;
      ST_PRGA_OUT: begin
        pt_we = 1'b1;
        if (CHECK_EN && !is_accepted_char(pt_byte)) begin
          state_d = ST_NEXT_KEY;
        end else if (k_q == AW'(MSG_DEP - 1)) begin
          found_d     = 1'b1;
          found_key_d = cur_key_q;
          state_d     = ST_FINISH;
        end else begin
          k_d     = k_q + AW'(1);
          state_d = ST_PRGA_IJ;
        end
      end
      // Compare before increment so key_hi of all-ones terminates without wrapping.
      ST_NEXT_KEY: begin
        if (cur_key_q == key_hi_q) begin
          found_d = 1'b0;
          state_d = ST_FINISH;
        end else begin
          cur_key_d = cur_key_q + KEY_BITS'(1);
          state_d   = ST_INIT;
        end
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      found_d = 1'b0;
      pt_we   = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      kidx_q      <= '0;
      cur_key_q   <= '0;
      key_hi_q    <= '0;
      found_key_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      kidx_q      <= kidx_d;
      cur_key_q   <= cur_key_d;
      key_hi_q    <= key_hi_d;
      found_key_q <= found_key_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      found_q     <= found_d;
    end
  end

  // S is refilled on every INIT, so it needs no reset.
  always_ff @(posedge CLOCK_50) begin
    if (state_q == ST_INIT) begin
      for (int unsigned n = 0; n < S_DEP; n++) s_q[8'(n)] <= 8'(n);
    end else if ((state_q == ST_KSA_SWAP) || (state_q == ST_PRGA_SWAP)) begin
      s_q[i_q] <= sj;
      s_q[j_q] <= si;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign found     = found_q;
  assign found_key = found_key_q;
  assign cur_key   = cur_key_q;

endmodule

// File: tb/tb_rc4_key_search_core.sv
// Directed bench: a CHECK_EN=0 instance on the "Key"/"Plaintext" vector and a CHECK_EN=1 searcher.
module tb_rc4_key_search_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_start, a_abort, a_ct_we;
  logic [23:0] a_key_lo, a_key_hi, a_found_key, a_cur_key;
  logic [3:0]  a_ct_addr, a_pt_addr;
  logic [7:0]  a_ct_data, a_pt_data;
  logic        a_busy, a_done, a_found;

  logic        b_rst, b_start, b_abort, b_ct_we;
  logic [21:0] b_key_lo, b_key_hi, b_found_key, b_cur_key;
  logic [4:0]  b_ct_addr, b_pt_addr;
  logic [7:0]  b_ct_data, b_pt_data;
  logic        b_busy, b_done, b_found;

  rc4_key_search_core #(.KEY_BYTES(3), .KEY_BITS(24), .MSG_DEP(9), .CHECK_EN(1'b0)) u_dut_a (
    .CLOCK_50(clk), .reset(a_rst), .start(a_start), .abort(a_abort),
    .key_lo(a_key_lo), .key_hi(a_key_hi),
    .ct_wr_en(a_ct_we), .ct_wr_addr(a_ct_addr), .ct_wr_data(a_ct_data),
    .pt_rd_addr(a_pt_addr), .pt_rd_data(a_pt_data),
    .busy(a_busy), .done(a_done), .found(a_found),
    .found_key(a_found_key), .cur_key(a_cur_key)
  );

  rc4_key_search_core #(.KEY_BYTES(3), .KEY_BITS(22), .MSG_DEP(32), .CHECK_EN(1'b1)) u_dut_b (
    .CLOCK_50(clk), .reset(b_rst), .start(b_start), .abort(b_abort),
    .key_lo(b_key_lo), .key_hi(b_key_hi),
    .ct_wr_en(b_ct_we), .ct_wr_addr(b_ct_addr), .ct_wr_data(b_ct_data),
    .pt_rd_addr(b_pt_addr), .pt_rd_data(b_pt_data),
    .busy(b_busy), .done(b_done), .found(b_found),
    .found_key(b_found_key), .cur_key(b_cur_key)
  );

  typedef struct {
    logic [3:0] addr;
    logic [7:0] ct;
    logic [7:0] pt;
  } a_vec_t;

  typedef struct {
    logic [21:0] lo;
    logic [21:0] hi;
    bit          found;
    logic [21:0] key;
    logic [21:0] cur;
    int          cycles;
  } run_vec_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  string      msg;
  logic [7:0] ks_m [32];
  logic [7:0] ct_b [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference RC4 keystream for a 3-byte key, first 32 bytes.
  task automatic model_ks(input logic [23:0] key);
    logic [7:0] s [256];
    logic [7:0] i, j, t, kb;
    for (int n = 0; n < 256; n++) s[n] = 8'(n);
    j = 8'd0;
    for (int n = 0; n < 256; n++) begin
      kb   = 8'(key >> (8 * (2 - (n % 3))));
      j    = j + s[n] + kb;
      t    = s[n];
      s[n] = s[j];
      s[j] = t;
    end
    i = 8'd0;
    j = 8'd0;
    for (int n = 0; n < 32; n++) begin
      i        = i + 8'd1;
      j        = j + s[i];
      t        = s[i];
      s[i]     = s[j];
      s[j]     = t;
      t        = s[i] + s[j];
      ks_m[n]  = s[t];
    end
  endtask

  task automatic do_start_b(input logic [21:0] lo, input logic [21:0] hi);
    @(negedge clk);
    b_key_lo = lo;
    b_key_hi = hi;
    b_start  = 1'b1;
    @(posedge clk);
    #1;
    b_start = 1'b0;
  endtask

  task automatic wait_done_b(output int cycles);
    bit to;
    to     = 1'b0;
    cycles = 0;
    while ((b_done !== 1'b1) && !to) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles >= 30000) to = 1'b1;
    end
    check("b_done_timeout", 32'(to), 32'd0);
  endtask

  task automatic check_pt_b(input string tag);
    for (int n = 0; n < 32; n++) begin
      b_pt_addr = 5'(n);
      #1;
      check($sformatf("%s_pt[%0d]", tag, n), 32'(b_pt_data), 32'(8'(msg[n])));
    end
  endtask

  initial begin
    a_vec_t   av [9];
    run_vec_t rv [5];
    int       cyc;
    bit       to;

    av[0] = '{4'd0, 8'hBB, 8'h50};
    av[1] = '{4'd1, 8'hF3, 8'h6C};
    av[2] = '{4'd2, 8'h16, 8'h61};
    av[3] = '{4'd3, 8'hE8, 8'h69};
    av[4] = '{4'd4, 8'hD9, 8'h6E};
    av[5] = '{4'd5, 8'h40, 8'h74};
    av[6] = '{4'd6, 8'hAF, 8'h65};
    av[7] = '{4'd7, 8'h0A, 8'h78};
    av[8] = '{4'd8, 8'hD3, 8'h74};

    rv[0] = '{22'h000040, 22'h000050, 1'b1, 22'h000049, 22'h000049, -1};
    rv[1] = '{22'h000050, 22'h000060, 1'b0, 22'h000000, 22'h000060, -1};
    rv[2] = '{22'h000010, 22'h00000F, 1'b0, 22'h000000, 22'h000010, 1};
    rv[3] = '{22'h3FFFFE, 22'h3FFFFF, 1'b0, 22'h000000, 22'h3FFFFF, -1};
    rv[4] = '{22'h000049, 22'h000049, 1'b1, 22'h000049, 22'h000049, 610};

    msg = "the quick brown fox jumps over a";
    model_ks(24'h000049);
    for (int n = 0; n < 32; n++) ct_b[n] = 8'(msg[n]) ^ ks_m[n];

    a_rst = 1'b1; a_start = 1'b0; a_abort = 1'b0; a_ct_we = 1'b0;
    a_key_lo = '0; a_key_hi = '0; a_ct_addr = '0; a_ct_data = '0; a_pt_addr = '0;
    b_rst = 1'b1; b_start = 1'b0; b_abort = 1'b0; b_ct_we = 1'b0;
    b_key_lo = '0; b_key_hi = '0; b_ct_addr = '0; b_ct_data = '0; b_pt_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    a_rst = 1'b0;
    b_rst = 1'b0;

    check("a_rst_busy", a_busy, 0);
    check("a_rst_done", a_done, 0);
    check("a_rst_found", a_found, 0);
    check("a_rst_found_key", a_found_key, 0);
    check("a_rst_cur_key", a_cur_key, 0);
    check("b_rst_busy", b_busy, 0);
    check("b_rst_done", b_done, 0);
    check("b_rst_found", b_found, 0);
    check("b_rst_found_key", b_found_key, 0);
    check("b_rst_cur_key", b_cur_key, 0);

    // Instance A: fixed key "Key", no checking; key_hi below key_lo must not matter.
    for (int n = 0; n < 9; n++) begin
      @(negedge clk);
      a_ct_we = 1'b1; a_ct_addr = av[n].addr; a_ct_data = av[n].ct;
    end
    @(negedge clk);
    a_ct_we  = 1'b0;
    a_key_lo = 24'h4B6579;
    a_key_hi = 24'h000000;
    a_start  = 1'b1;
    @(posedge clk);
    #1;
    a_start = 1'b0;
    check("a_busy_on_start", a_busy, 1);
    cyc = 0;
    to  = 1'b0;
    while ((a_done !== 1'b1) && !to) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc >= 5000) to = 1'b1;
    end
    check("a_done_timeout", 32'(to), 32'd0);
    check("a_cycles", cyc, 541);
    check("a_found", a_found, 1);
    check("a_found_key", a_found_key, 32'h4B6579);
    check("a_busy_done", a_busy, 0);
    for (int n = 0; n < 9; n++) begin
      a_pt_addr = av[n].addr;
      #1;
      check($sformatf("a_pt[%0d]", n), 32'(a_pt_data), 32'(av[n].pt));
    end

    // Instance B: load ciphertext, then the search-range table.
    for (int n = 0; n < 32; n++) begin
      @(negedge clk);
      b_ct_we = 1'b1; b_ct_addr = 5'(n); b_ct_data = ct_b[n];
    end
    @(negedge clk);
    b_ct_we = 1'b0;

    for (int v = 0; v < 5; v++) begin
      do_start_b(rv[v].lo, rv[v].hi);
      check($sformatf("v%0d_busy_on_start", v), b_busy, 1);
      wait_done_b(cyc);
      check($sformatf("v%0d_found", v), b_found, 32'(rv[v].found));
      if (rv[v].found) check($sformatf("v%0d_found_key", v), b_found_key, rv[v].key);
      check($sformatf("v%0d_cur_key", v), b_cur_key, rv[v].cur);
      if (rv[v].cycles >= 0) check($sformatf("v%0d_cycles", v), cyc, rv[v].cycles);
      check($sformatf("v%0d_busy_done", v), b_busy, 0);
    end
    check_pt_b("v4");

    // Abort mid-KSA, then a clean rerun.
    do_start_b(22'h000040, 22'h000050);
    repeat (100) @(posedge clk);
    #1;
    check("abort_pre_busy", b_busy, 1);
    @(negedge clk);
    b_abort = 1'b1;
    @(posedge clk);
    #1;
    b_abort = 1'b0;
    check("abort_busy", b_busy, 0);
    check("abort_done", b_done, 0);
    check("abort_found", b_found, 0);
    do_start_b(22'h000040, 22'h000050);
    wait_done_b(cyc);
    check("abort_rerun_found", b_found, 1);
    check("abort_rerun_key", b_found_key, 32'h49);

    // Reset mid-KSA clears all outputs; rerun a single key.
    do_start_b(22'h000049, 22'h000049);
    repeat (300) @(posedge clk);
    @(negedge clk);
    b_rst = 1'b1;
    @(posedge clk);
    #1;
    b_rst = 1'b0;
    check("reset_busy", b_busy, 0);
    check("reset_done", b_done, 0);
    check("reset_found", b_found, 0);
    check("reset_found_key", b_found_key, 0);
    check("reset_cur_key", b_cur_key, 0);
    do_start_b(22'h000049, 22'h000049);
    wait_done_b(cyc);
    check("reset_rerun_cycles", cyc, 610);
    check("reset_rerun_found", b_found, 1);
    check("reset_rerun_key", b_found_key, 32'h49);

    // start and ct writes while busy must be ignored.
    do_start_b(22'h000040, 22'h000050);
    repeat (50) @(posedge clk);
    @(negedge clk);
    b_start   = 1'b1;
    b_key_lo  = 22'h000050;
    b_key_hi  = 22'h000060;
    b_ct_we   = 1'b1;
    b_ct_addr = 5'd0;
    b_ct_data = ~ct_b[0];
    @(posedge clk);
    #1;
    b_start = 1'b0;
    b_ct_we = 1'b0;
    wait_done_b(cyc);
    check("busy_ign_found", b_found, 1);
    check("busy_ign_key", b_found_key, 32'h49);
    check("busy_ign_cur_key", b_cur_key, 32'h49);
    check_pt_b("busy_ign");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
